// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a shared BCD-to-7-segment decoder.
// Double-buffered digit storage, anti-ghosting gaps, leading-zero and invalid-digit blanking.
module disp_scan_ctrl #(
   parameter int NDIG     = 4,
   parameter int SCAN_DIV = 1000,
   parameter int GAP_CYC  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [4*NDIG-1:0] din,
   input  logic              lzb,
   output logic [3:0]        wdata,
   output logic [NDIG-1:0]   sel,
   output logic              frame_done,
   output logic              bcd_err,
   output logic [1:0]        dbg_state
);

   localparam int CNT_MAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int IW      = $clog2(NDIG);

   localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2
   } scan_state_t;

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic              w_wrap;

   logic [4*NDIG-1:0] r_act;
   logic [4*NDIG-1:0] r_pend;
   logic              r_pend_v;
   logic              w_xfer;
   logic [4*NDIG-1:0] w_act_nxt;

   logic [3:0]        w_dig [NDIG];
   logic [NDIG-1:0]   w_bad_act;
   logic              w_hi_zero;
   logic              w_blank;

   logic [3:0]        r_wdata;
   logic [3:0]        w_wdata_nxt;
   logic [NDIG-1:0]   r_sel;
   logic [NDIG-1:0]   w_sel_nxt;
   logic              r_frame_done;
   logic              r_bcd_err;

   // ------------------------------------------------------------------
   // Scan FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_OFF;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // w_wrap marks the end of the last slot of the top digit (frame boundary)
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_wrap      = 1'b0;
      case (r_state)
         ST_OFF: begin
            w_idx_nxt = '0;
            w_cnt_nxt = '0;
            if (en) begin
               w_state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (r_cnt == SHOW_LAST) begin
               w_cnt_nxt = '0;
               if (GAP_CYC > 0) begin
                  w_state_nxt = ST_GAP;
               end else begin
                  w_wrap    = (r_idx == IDX_LAST);
                  w_idx_nxt = w_wrap ? '0 : r_idx + 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHOW;
               w_wrap      = (r_idx == IDX_LAST);
               w_idx_nxt   = w_wrap ? '0 : r_idx + 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
      if (!en) begin
         w_state_nxt = ST_OFF;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
      end
   end

   // ------------------------------------------------------------------
   // Double buffer: a load coinciding with a transfer stays pending
   // ------------------------------------------------------------------
   assign w_xfer    = r_pend_v && ((r_state == ST_OFF) || w_wrap);
   assign w_act_nxt = w_xfer ? r_pend : r_act;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_act    <= '0;
         r_pend   <= '0;
         r_pend_v <= 1'b0;
      end else begin
         r_act <= w_act_nxt;
         if (load) begin
            r_pend   <= din;
            r_pend_v <= 1'b1;
         end else if (w_xfer) begin
            r_pend_v <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Digit decode and blanking, evaluated for the state being entered
   // ------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NDIG; i++) begin
         w_dig[i]     = w_act_nxt[4*i +: 4];
         w_bad_act[i] = (r_act[4*i +: 4] > 4'd9);
      end
   end

   always_comb begin
      w_hi_zero = 1'b1;
      for (int j = 0; j < NDIG; j++) begin
         if ((IW'(j) >= w_idx_nxt) && (w_dig[j] != 4'd0)) begin
            w_hi_zero = 1'b0;
         end
      end
   end

   assign w_blank = (w_dig[w_idx_nxt] > 4'd9) ||
                    (lzb && (w_idx_nxt != '0) && w_hi_zero);

   always_comb begin
      w_sel_nxt   = '1;
      w_wdata_nxt = r_wdata;
      if (w_state_nxt == ST_SHOW) begin
         w_wdata_nxt = w_dig[w_idx_nxt];
         if (!w_blank) begin
            w_sel_nxt[w_idx_nxt] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdata      <= '0;
         r_sel        <= '1;
         r_frame_done <= 1'b0;
         r_bcd_err    <= 1'b0;
      end else begin
         r_wdata      <= w_wdata_nxt;
         r_sel        <= w_sel_nxt;
         r_frame_done <= w_wrap && en;
         r_bcd_err    <= |w_bad_act;
      end
   end

   assign wdata      = r_wdata;
   assign sel        = r_sel;
   assign frame_done = r_frame_done;
   assign bcd_err    = r_bcd_err;
   assign dbg_state  = r_state;

endmodule
